i2c_target_regs: RTL and testbench

//  I2C target (slave) responder for the Nios I2C master bus. It exposes a byte-addressed register

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_filter.sv | 54 +++++
 rtl/i2c_target_regs.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK line levels and the default target address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] I2C_DEF_DEV_ADDR = 7'h42;

endpackage

// File: rtl/i2c_line_filter.sv
// Bus line conditioner: 2-FF synchroniser, glitch filter needing FILT_LEN agreeing samples,
// and single-cycle rise/fall strobes aligned with the filtered level change.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Idle bus level is high, so the filter comes out of reset believing the line is released.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_lvl  <= 1'b1;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_in;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_lvl  <= r_s2;
        r_cnt  <= '0;
        r_rise <= r_s2;
        r_fall <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-addressed register window: pointer write, then burst
// read or write with auto-increment. Open-drain pins; SCL is never stretched.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEF_DEV_ADDR,
  parameter int         REG_AW   = 4,
  parameter int         FILT_LEN = 3
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              i2c_sda_in,
  input  logic              i2c_scl_in,
  output logic              i2c_sda_oe,
  output logic              i2c_scl_oe,
  output logic              reg_wr_valid,
  output logic [7:0]        reg_wr_data,
  output logic              reg_rd_req,
  input  logic [7:0]        reg_rd_data,
  output logic [REG_AW-1:0] reg_addr,
  output logic              busy
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_scl_edge, w_start, w_stop;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .i_clk (clk_clk),
    .i_rst (reset_reset),
    .i_in  (i2c_scl_in),
    .o_lvl (w_scl_lvl),
    .o_rise(w_scl_rise),
    .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .i_clk (clk_clk),
    .i_rst (reset_reset),
    .i_in  (i2c_sda_in),
    .o_lvl (w_sda_lvl),
    .o_rise(w_sda_rise),
    .o_fall(w_sda_fall)
  );

  // An SCL edge in the same clock as an SDA edge means a data change, never a bus condition.
  assign w_scl_edge = w_scl_rise | w_scl_fall;
  assign w_start    = w_sda_fall & w_scl_lvl & ~w_scl_edge;
  assign w_stop     = w_sda_rise & w_scl_lvl & ~w_scl_edge;

  i2c_tgt_state_t    r_state, w_state_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [3:0]        r_bitcnt, w_bitcnt_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_mack, w_mack_nxt;
  logic              r_sda_oe, w_sda_oe_nxt;
  logic              r_wr_valid, w_wr_valid_nxt;
  logic [7:0]        r_wr_data, w_wr_data_nxt;
  logic              r_rd_req, w_rd_req_nxt;
  logic              r_ld_p1;
  logic [REG_AW-1:0] r_addr, w_addr_nxt;
  logic              r_busy, w_busy_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bitcnt_nxt   = r_bitcnt;
    w_rw_nxt       = r_rw;
    w_mack_nxt     = r_mack;
    w_sda_oe_nxt   = r_sda_oe;
    w_wr_valid_nxt = 1'b0;
    w_wr_data_nxt  = r_wr_data;
    w_rd_req_nxt   = 1'b0;
    w_addr_nxt     = r_addr;
    w_busy_nxt     = r_busy;

    if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_bitcnt_nxt = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b1;
    end else begin
      // Fabric data arrives one clock after the request; present its MSB straight away.
      if (r_ld_p1) begin
        w_shift_nxt  = reg_rd_data;
        w_sda_oe_nxt = ~reg_rd_data[7];
      end
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise && r_bitcnt < 4'd8) begin
            w_shift_nxt  = {r_shift[6:0], w_sda_lvl};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_state == ST_WDATA && r_bitcnt == 4'd7) begin
              w_wr_valid_nxt = 1'b1;
              w_wr_data_nxt  = {r_shift[6:0], w_sda_lvl};
            end
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            if (r_state == ST_ADDR) begin
              if (r_shift[7:1] == DEV_ADDR) begin
                w_state_nxt  = ST_ADDR_ACK;
                w_sda_oe_nxt = 1'b1;
                w_rw_nxt     = r_shift[0];
              end else begin
                w_state_nxt = ST_IGNORE;
              end
            end else if (r_state == ST_PTR) begin
              w_state_nxt  = ST_PTR_ACK;
              w_sda_oe_nxt = 1'b1;
              w_addr_nxt   = r_shift[REG_AW-1:0];
            end else begin
              w_state_nxt  = ST_WDATA_ACK;
              w_sda_oe_nxt = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = 4'd0;
            if (r_rw) begin
              w_state_nxt  = ST_RDATA;
              w_rd_req_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_PTR;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = 4'd0;
            w_state_nxt  = ST_WDATA;
            if (r_state == ST_WDATA_ACK) w_addr_nxt = r_addr + REG_AW'(1);
          end
        end
        ST_RDATA: begin
          if (w_scl_rise && r_bitcnt < 4'd8) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_state_nxt  = ST_RDATA_ACK;
            w_sda_oe_nxt = 1'b0;
          end else if (w_scl_fall && r_bitcnt != 4'd0) begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_mack_nxt = w_sda_lvl;
          end else if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = 4'd0;
            if (r_mack == I2C_ACK) begin
              w_state_nxt  = ST_RDATA;
              w_addr_nxt   = r_addr + REG_AW'(1);
              w_rd_req_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    r_shift <= w_shift_nxt;
    r_rw    <= w_rw_nxt;
    r_mack  <= w_mack_nxt;
    if (reset_reset) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= 4'd0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_data  <= 8'd0;
      r_rd_req   <= 1'b0;
      r_ld_p1    <= 1'b0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rd_req   <= w_rd_req_nxt;
      r_ld_p1    <= r_rd_req;
      r_addr     <= w_addr_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign i2c_sda_oe   = r_sda_oe;
  assign i2c_scl_oe   = 1'b0;
  assign reg_wr_valid = r_wr_valid;
  assign reg_wr_data  = r_wr_data;
  assign reg_rd_req   = r_rd_req;
  assign reg_addr     = r_addr;
  assign busy         = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register-fabric model and scoreboard
// queues of expected write strobes and read requests.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_sda = 1'b1;
  logic       m_scl = 1'b1;
  logic       sda_line, scl_line;
  logic       sda_oe, scl_oe, wr_valid, rd_req, busy;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'd0;
  logic [3:0] reg_addr;

  always #5 clk = ~clk;

  assign sda_line = m_sda & ~sda_oe;
  assign scl_line = m_scl & ~scl_oe;

  i2c_target_regs #(.DEV_ADDR(7'h42), .REG_AW(4), .FILT_LEN(3)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .i2c_sda_in  (sda_line),
    .i2c_scl_in  (scl_line),
    .i2c_sda_oe  (sda_oe),
    .i2c_scl_oe  (scl_oe),
    .reg_wr_valid(wr_valid),
    .reg_wr_data (wr_data),
    .reg_rd_req  (rd_req),
    .reg_rd_data (rd_data),
    .reg_addr    (reg_addr),
    .busy        (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Register fabric, and the bench's own expectation of its contents.
  logic [7:0]  fab_mem [16];
  logic [7:0]  exp_mem [16];
  logic [11:0] wr_q [$];
  logic [3:0]  rd_q [$];
  logic [11:0] e_wr;
  logic [3:0]  e_rd;
  logic        watch_oe = 1'b0;
  logic        oe_seen  = 1'b0;

  always @(posedge clk) begin
    if (wr_valid) fab_mem[reg_addr] <= wr_data;
    if (rd_req)   rd_data <= fab_mem[reg_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid) begin
        e_wr = (wr_q.size() > 0) ? wr_q.pop_front() : 12'hxxx;
        check("wr_strobe", {20'd0, reg_addr, wr_data}, {20'd0, e_wr});
      end
      if (rd_req) begin
        e_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 4'hx;
        check("rd_req_addr", {28'd0, reg_addr}, {28'd0, e_rd});
      end
      if (watch_oe && sda_oe) oe_seen = 1'b1;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wclk(10);
    m_scl = 1'b1; wclk(20);
    m_sda = 1'b0; wclk(20);
    m_scl = 1'b0; wclk(10);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wclk(10);
    m_scl = 1'b1; wclk(20);
    m_sda = 1'b1; wclk(20);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wclk(10);
    m_scl = 1'b1; wclk(20);
    m_scl = 1'b0; wclk(10);
  endtask

  // Same bit timing, but with a one-clock SCL glitch in both the low and the high phase.
  task automatic write_bit_glitch(input logic b);
    m_sda = b;    wclk(5);
    m_scl = 1'b1; wclk(1);
    m_scl = 1'b0; wclk(4);
    m_scl = 1'b1; wclk(10);
    m_scl = 1'b0; wclk(1);
    m_scl = 1'b1; wclk(9);
    m_scl = 1'b0; wclk(10);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wclk(10);
    m_scl = 1'b1; wclk(10);
    @(negedge clk);
    b = sda_line;
    wclk(10);
    m_scl = 1'b0; wclk(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(mack);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] gb;

    for (int i = 0; i < 16; i++) begin
      logic [3:0] k;
      k = 4'(i);
      exp_mem[i] = {k, ~k};
      fab_mem[i] = {k, ~k};
    end

    rst = 1'b1;
    wclk(5);
    @(negedge clk);
    check("rst_sda_oe",   {31'd0, sda_oe},   0);
    check("rst_scl_oe",   {31'd0, scl_oe},   0);
    check("rst_wr_valid", {31'd0, wr_valid}, 0);
    check("rst_rd_req",   {31'd0, rd_req},   0);
    check("rst_wr_data",  {24'd0, wr_data},  0);
    check("rst_reg_addr", {28'd0, reg_addr}, 0);
    check("rst_busy",     {31'd0, busy},     0);
    rst = 1'b0;
    wclk(30);

    // Pointer write then two data bytes with auto-increment.
    i2c_start();
    check("wr_busy", {31'd0, busy}, 1);
    write_byte(8'h84, ack); check("wr_addr_ack", {31'd0, ack}, 0);
    write_byte(8'h03, ack); check("wr_ptr_ack", {31'd0, ack}, 0);
    wr_q.push_back({4'h3, 8'hA5}); exp_mem[3] = 8'hA5;
    write_byte(8'hA5, ack); check("wr_d0_ack", {31'd0, ack}, 0);
    wr_q.push_back({4'h4, 8'h5A}); exp_mem[4] = 8'h5A;
    write_byte(8'h5A, ack); check("wr_d1_ack", {31'd0, ack}, 0);
    i2c_stop();
    wclk(10);
    check("wr_busy_after_stop", {31'd0, busy}, 0);
    check("wr_all_strobes", wr_q.size(), 0);

    // Pointer 0x0E, repeated START, three reads wrapping to 0x00.
    i2c_start();
    write_byte(8'h84, ack); check("rd_addr_ack", {31'd0, ack}, 0);
    write_byte(8'h0E, ack); check("rd_ptr_ack", {31'd0, ack}, 0);
    i2c_start();
    rd_q.push_back(4'hE);
    write_byte(8'h85, ack); check("rd_addr_r_ack", {31'd0, ack}, 0);
    rd_q.push_back(4'hF);
    read_byte(d, I2C_ACK);  check("rd_byte_0e", {24'd0, d}, {24'd0, exp_mem[14]});
    rd_q.push_back(4'h0);
    read_byte(d, I2C_ACK);  check("rd_byte_0f", {24'd0, d}, {24'd0, exp_mem[15]});
    read_byte(d, I2C_NACK); check("rd_byte_00", {24'd0, d}, {24'd0, exp_mem[0]});
    i2c_stop();
    wclk(10);
    check("rd_addr_wrapped", {28'd0, reg_addr}, 0);
    check("rd_all_reqs", rd_q.size(), 0);
    check("rd_busy_after_stop", {31'd0, busy}, 0);

    // Foreign address: the target must stay silent for the whole frame.
    oe_seen = 1'b0;
    watch_oe = 1'b1;
    i2c_start();
    write_byte(8'h90, ack); check("wa_addr_nack", {31'd0, ack}, 1);
    check("wa_busy", {31'd0, busy}, 1);
    write_byte(8'h11, ack); check("wa_data_nack", {31'd0, ack}, 1);
    i2c_stop();
    watch_oe = 1'b0;
    check("wa_sda_never_driven", {31'd0, oe_seen}, 0);
    i2c_start();
    write_byte(8'h84, ack); check("wa_next_ack", {31'd0, ack}, 0);
    i2c_stop();

    // STOP after four data bits: partial byte discarded.
    i2c_start();
    write_byte(8'h84, ack); check("ab_addr_ack", {31'd0, ack}, 0);
    write_byte(8'h07, ack); check("ab_ptr_ack", {31'd0, ack}, 0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    wclk(10);
    check("ab_busy", {31'd0, busy}, 0);
    check("ab_state_idle", {28'd0, dut.r_state}, {28'd0, ST_IDLE});
    check("ab_ptr_kept", {28'd0, reg_addr}, 7);

    // Data byte written with SCL glitches, then read back.
    i2c_start();
    write_byte(8'h84, ack); check("gl_addr_ack", {31'd0, ack}, 0);
    write_byte(8'h09, ack); check("gl_ptr_ack", {31'd0, ack}, 0);
    gb = 8'hC3;
    wr_q.push_back({4'h9, gb}); exp_mem[9] = gb;
    for (int i = 7; i >= 0; i--) write_bit_glitch(gb[i]);
    read_bit(ack); check("gl_data_ack", {31'd0, ack}, 0);
    i2c_stop();
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h09, ack);
    i2c_start();
    rd_q.push_back(4'h9);
    write_byte(8'h85, ack); check("gl_rd_ack", {31'd0, ack}, 0);
    read_byte(d, I2C_NACK); check("gl_readback", {24'd0, d}, {24'd0, exp_mem[9]});
    i2c_stop();
    check("gl_all_strobes", wr_q.size() + rd_q.size(), 0);

    // Reset while the target drives a 0 data bit.
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h02, ack);
    i2c_start();
    rd_q.push_back(4'h2);
    write_byte(8'h85, ack); check("rs_addr_ack", {31'd0, ack}, 0);
    m_sda = 1'b1;
    for (int i = 0; i < 50 && !sda_oe; i++) @(negedge clk);
    @(negedge clk);
    check("rs_drive_zero", {31'd0, sda_oe}, {31'd0, ~exp_mem[2][7]});
    rst = 1'b1;
    @(negedge clk);
    check("rs_sda_released", {31'd0, sda_oe}, 0);
    check("rs_addr_cleared", {28'd0, reg_addr}, 0);
    check("rs_busy_cleared", {31'd0, busy}, 0);
    rst = 1'b0;
    wclk(30);
    i2c_stop();
    wclk(10);
    check("rs_queues_empty", wr_q.size() + rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
